// File: rtl/bsg_fpu_clz_pipe_if.sv
// Handshake and data bundle for the pipelined leading-zero/one counter.
// The slave side belongs to the counter; the master side is its producer and consumer.
interface bsg_fpu_clz_pipe_if #(
    parameter int width_p     = 32,
    parameter int tag_width_p = 4
);
    localparam int cnt_width_lp = $clog2(width_p + 1);

    logic [width_p-1:0]      data_i;
    logic                    mode_i;
    logic [tag_width_p-1:0]  tag_i;
    logic                    v_i;
    logic                    ready_o;
    logic [cnt_width_lp-1:0] count_o;
    logic                    all_o;
    logic [width_p-1:0]      norm_o;
    logic [tag_width_p-1:0]  tag_o;
    logic                    v_o;
    logic                    yumi_i;

    modport slave (
        input  data_i, mode_i, tag_i, v_i, yumi_i,
        output ready_o, count_o, all_o, norm_o, tag_o, v_o
    );

    modport master (
        output data_i, mode_i, tag_i, v_i, yumi_i,
        input  ready_o, count_o, all_o, norm_o, tag_o, v_o
    );
endinterface

// File: rtl/bsg_fpu_clz_pipe.sv
// Pipelined leading-zero/one count plus left-normalise; latency 2 cycles, 1/cycle throughput.
// Backpressure via yumi_i: s2 holds while unconsumed, ready_o drops only when both stages are full.
module bsg_fpu_clz_pipe #(
    parameter int width_p     = 32,
    parameter int chunk_p     = 8,
    parameter int tag_width_p = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    bsg_fpu_clz_pipe_if.slave     io
);
    localparam int cnt_width_lp  = $clog2(width_p + 1);
    localparam int num_chunks_lp = width_p / chunk_p;
    localparam int idx_width_lp  = (num_chunks_lp > 1) ? $clog2(num_chunks_lp) : 1;

    logic                    s1_v_q,    s1_v_d;
    logic [width_p-1:0]      s1_data_q, s1_data_d;
    logic                    s1_mode_q, s1_mode_d;
    logic [tag_width_p-1:0]  s1_tag_q,  s1_tag_d;
    logic [idx_width_lp-1:0] s1_idx_q,  s1_idx_d;
    logic                    s1_all_q,  s1_all_d;

    logic                    s2_v_q,    s2_v_d;
    logic [cnt_width_lp-1:0] count_q,   count_d;
    logic                    all_q,     all_d;
    logic [width_p-1:0]      norm_q,    norm_d;
    logic [tag_width_p-1:0]  tag_q,     tag_d;

    logic                     s2_en, s1_move, accept;
    logic [width_p-1:0]       x1, x2;
    logic [num_chunks_lp-1:0] chunk_nz;
    logic [idx_width_lp-1:0]  idx1;
    logic [chunk_p-1:0]       sel;
    int                       icnt, cnt2;

    always_comb begin
        s2_en   = ~s2_v_q | io.yumi_i;
        s1_move = s1_v_q & s2_en;
        accept  = io.v_i & (~s1_v_q | s1_move);
    end

    assign io.ready_o = ~s1_v_q | s1_move;

    // Stage 1: coarse search; chunk 0 is the most-significant chunk of x.
    always_comb begin
        x1       = io.mode_i ? ~io.data_i : io.data_i;
        chunk_nz = '0;
        for (int c = 0; c < num_chunks_lp; c++) begin
            chunk_nz[c] = |x1[width_p-1-c*chunk_p -: chunk_p];
        end
        idx1 = '0;
        for (int c = num_chunks_lp - 1; c >= 0; c--) begin
            if (chunk_nz[c]) idx1 = idx_width_lp'(c);
        end
    end

    // Stage 2: fine search within the selected chunk, then normalise the raw data.
    always_comb begin
        x2   = s1_mode_q ? ~s1_data_q : s1_data_q;
        sel  = x2[width_p-1-int'(s1_idx_q)*chunk_p -: chunk_p];
        icnt = chunk_p;
        for (int i = 0; i < chunk_p; i++) begin
            if (sel[i]) icnt = chunk_p - 1 - i;
        end
        cnt2 = s1_all_q ? width_p : int'(s1_idx_q) * chunk_p + icnt;
    end

    always_comb begin
        s1_v_d    = accept | (s1_v_q & ~s1_move);
        s1_data_d = s1_data_q;
        s1_mode_d = s1_mode_q;
        s1_tag_d  = s1_tag_q;
        s1_idx_d  = s1_idx_q;
        s1_all_d  = s1_all_q;
        if (accept) begin
            s1_data_d = io.data_i;
            s1_mode_d = io.mode_i;
            s1_tag_d  = io.tag_i;
            s1_idx_d  = idx1;
            s1_all_d  = ~|x1;
        end

        s2_v_d  = s2_en ? s1_v_q : s2_v_q;
        count_d = count_q;
        all_d   = all_q;
        norm_d  = norm_q;
        tag_d   = tag_q;
        if (s1_move) begin
            count_d = cnt_width_lp'(cnt2);
            all_d   = s1_all_q;
            norm_d  = s1_all_q ? '0 : (s1_data_q << cnt2);
            tag_d   = s1_tag_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            s1_v_q    <= 1'b0;
            s1_data_q <= '0;
            s1_mode_q <= 1'b0;
            s1_tag_q  <= '0;
            s1_idx_q  <= '0;
            s1_all_q  <= 1'b0;
            s2_v_q    <= 1'b0;
            count_q   <= '0;
            all_q     <= 1'b0;
            norm_q    <= '0;
            tag_q     <= '0;
        end else begin
            s1_v_q    <= s1_v_d;
            s1_data_q <= s1_data_d;
            s1_mode_q <= s1_mode_d;
            s1_tag_q  <= s1_tag_d;
            s1_idx_q  <= s1_idx_d;
            s1_all_q  <= s1_all_d;
            s2_v_q    <= s2_v_d;
            count_q   <= count_d;
            all_q     <= all_d;
            norm_q    <= norm_d;
            tag_q     <= tag_d;
        end
    end

    assign io.count_o = count_q;
    assign io.all_o   = all_q;
    assign io.norm_o  = norm_q;
    assign io.tag_o   = tag_q;
    assign io.v_o     = s2_v_q;
endmodule

// File: tb/tb_bsg_fpu_clz_pipe.sv
// Directed bench for bsg_fpu_clz_pipe: main 32/8 instance plus a width/chunk sweep.
module tb_bsg_fpu_clz_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    int   n_asserts = 0;
    int   n_fail    = 0;

    bsg_fpu_clz_pipe_if #(.width_p(32), .tag_width_p(4)) io();
    bsg_fpu_clz_pipe #(.width_p(32), .chunk_p(8), .tag_width_p(4)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .io(io));

    logic [63:0] sw_data;
    logic        sw_mode;
    logic        sw_v;

    bsg_fpu_clz_pipe_if #(.width_p(8),  .tag_width_p(4)) io_a();
    bsg_fpu_clz_pipe_if #(.width_p(8),  .tag_width_p(4)) io_b();
    bsg_fpu_clz_pipe_if #(.width_p(24), .tag_width_p(4)) io_c();
    bsg_fpu_clz_pipe_if #(.width_p(64), .tag_width_p(4)) io_d();
    bsg_fpu_clz_pipe #(.width_p(8),  .chunk_p(1), .tag_width_p(4)) dut_a (.clk_i(clk), .reset_n_i(reset_n), .io(io_a));
    bsg_fpu_clz_pipe #(.width_p(8),  .chunk_p(8), .tag_width_p(4)) dut_b (.clk_i(clk), .reset_n_i(reset_n), .io(io_b));
    bsg_fpu_clz_pipe #(.width_p(24), .chunk_p(8), .tag_width_p(4)) dut_c (.clk_i(clk), .reset_n_i(reset_n), .io(io_c));
    bsg_fpu_clz_pipe #(.width_p(64), .chunk_p(1), .tag_width_p(4)) dut_d (.clk_i(clk), .reset_n_i(reset_n), .io(io_d));

    assign io_a.data_i = sw_data[7:0];  assign io_a.mode_i = sw_mode; assign io_a.v_i = sw_v;
    assign io_a.tag_i  = '0;            assign io_a.yumi_i = io_a.v_o;
    assign io_b.data_i = sw_data[7:0];  assign io_b.mode_i = sw_mode; assign io_b.v_i = sw_v;
    assign io_b.tag_i  = '0;            assign io_b.yumi_i = io_b.v_o;
    assign io_c.data_i = sw_data[23:0]; assign io_c.mode_i = sw_mode; assign io_c.v_i = sw_v;
    assign io_c.tag_i  = '0;            assign io_c.yumi_i = io_c.v_o;
    assign io_d.data_i = sw_data;       assign io_d.mode_i = sw_mode; assign io_d.v_i = sw_v;
    assign io_d.tag_i  = '0;            assign io_d.yumi_i = io_d.v_o;

    typedef struct packed {
        logic [31:0] data;
        logic        mode;
        logic [3:0]  tag;
        logic [5:0]  cnt;
        logic        all;
        logic [31:0] norm;
    } item_t;

    item_t stim_q[$];
    item_t exp_q[$];

    function automatic logic [63:0] msk(input int w);
        logic [63:0] one = 64'd1;
        return (w >= 64) ? '1 : ((one << w) - 64'd1);
    endfunction

    function automatic int ref_cnt(input logic [63:0] d, input int w, input logic m);
        int c = 0;
        bit stop = 1'b0;
        for (int i = w - 1; i >= 0; i--) begin
            if (!stop) begin
                if (d[i] == m) c++;
                else stop = 1'b1;
            end
        end
        return c;
    endfunction

    function automatic logic [63:0] ref_norm(input logic [63:0] d, input int w, input int c);
        return ((d & msk(w)) << c) & msk(w);
    endfunction

    function automatic item_t mk_hand(input logic [31:0] d, input logic m, input logic [3:0] t,
                                      input int c, input logic a, input logic [31:0] n);
        item_t it;
        it.data = d; it.mode = m; it.tag = t;
        it.cnt = 6'(c); it.all = a; it.norm = n;
        return it;
    endfunction

    function automatic item_t mk_model(input logic [31:0] d, input logic m, input logic [3:0] t);
        int c;
        c = ref_cnt({32'b0, d}, 32, m);
        return mk_hand(d, m, t, c, c == 32, 32'(ref_norm({32'b0, d}, 32, c)));
    endfunction

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
        end
    endtask

    // ymode: 0 = consumer stalled, 1 = consumer always takes, 2 = random producer and consumer
    task automatic cycle(input int ymode);
        io.v_i = (stim_q.size() > 0) && (ymode != 2 || $urandom_range(0, 1) == 1);
        if (stim_q.size() > 0) begin
            io.data_i = stim_q[0].data;
            io.mode_i = stim_q[0].mode;
            io.tag_i  = stim_q[0].tag;
        end
        io.yumi_i = io.v_o && (ymode == 1 || (ymode == 2 && $urandom_range(0, 1) == 1));
        @(negedge clk);
        if (io.yumi_i) begin
            chk("yumi_legal", 64'(io.v_o), 64'd1);
            chk("out_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                chk("count", 64'(io.count_o), 64'(exp_q[0].cnt));
                chk("all",   64'(io.all_o),   64'(exp_q[0].all));
                chk("norm",  64'(io.norm_o),  64'(exp_q[0].norm));
                chk("tag",   64'(io.tag_o),   64'(exp_q[0].tag));
                void'(exp_q.pop_front());
            end
        end
        if (io.v_i && io.ready_o) exp_q.push_back(stim_q.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int ymode, input int max_cyc, output int used);
        used = 0;
        while ((stim_q.size() > 0 || exp_q.size() > 0) && used < max_cyc) begin
            cycle(ymode);
            used++;
        end
        io.v_i    = 1'b0;
        io.yumi_i = 1'b0;
    endtask

    task automatic chk_sw(input string nm, input int w, input logic v, input logic [63:0] oc,
                          input logic oa, input logic [63:0] on);
        int c;
        c = ref_cnt(sw_data & msk(w), w, sw_mode);
        chk({nm, "_v"},     64'(v),  64'd1);
        chk({nm, "_count"}, oc,      64'(c));
        chk({nm, "_all"},   64'(oa), 64'(c == w));
        chk({nm, "_norm"},  on,      ref_norm(sw_data, w, c));
    endtask

    initial begin
        int used;
        logic seen;
        logic [31:0] d;
        logic m;

        reset_n = 1'b0;
        io.v_i = 1'b0; io.yumi_i = 1'b0; io.data_i = '0; io.mode_i = 1'b0; io.tag_i = '0;
        sw_v = 1'b0; sw_data = '0; sw_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        chk("rst_v_o",   64'(io.v_o),     64'd0);
        chk("rst_ready", 64'(io.ready_o), 64'd1);
        chk("rst_count", 64'(io.count_o), 64'd0);
        chk("rst_norm",  64'(io.norm_o),  64'd0);
        chk("rst_tag",   64'(io.tag_o),   64'd0);

        // Single transaction: latency and basic count
        stim_q.push_back(mk_hand(32'h0001_0000, 1'b0, 4'd3, 15, 1'b0, 32'h8000_0000));
        run(1, 20, used);
        chk("latency_cycles", 64'(used), 64'd3);

        // Boundary patterns streamed back-to-back
        stim_q.push_back(mk_hand(32'h0000_0000, 1'b0, 4'd4, 32, 1'b1, 32'h0));
        stim_q.push_back(mk_hand(32'hFFFF_FFFF, 1'b1, 4'd5, 32, 1'b1, 32'h0));
        stim_q.push_back(mk_hand(32'hFFFF_0F00, 1'b1, 4'd6, 16, 1'b0, 32'h0F00_0000));
        stim_q.push_back(mk_hand(32'h8000_0001, 1'b0, 4'd7, 0,  1'b0, 32'h8000_0001));
        stim_q.push_back(mk_hand(32'h7FFF_FFFF, 1'b1, 4'd8, 0,  1'b0, 32'h7FFF_FFFF));
        stim_q.push_back(mk_hand(32'h0000_0003, 1'b0, 4'd9, 30, 1'b0, 32'hC000_0000));
        run(1, 30, used);
        chk("stream_cycles", 64'(used), 64'd8);

        // Backpressure: pipe fills with two, then ready_o drops
        for (int i = 0; i < 4; i++)
            stim_q.push_back(mk_model(32'h0000_0100 << (i * 3), 1'b0, 4'(i)));
        run(0, 3, used);
        chk("bp_ready_low",  64'(io.ready_o),     64'd0);
        chk("bp_accepted",   64'(exp_q.size()),   64'd2);
        chk("bp_v_o",        64'(io.v_o),         64'd1);
        chk("bp_head_tag",   64'(io.tag_o),       64'd0);
        chk("bp_head_count", 64'(io.count_o),     64'd23);
        run(1, 20, used);
        chk("bp_drain_cycles", 64'(used), 64'd4);

        // Random producer and consumer against the reference model
        for (int i = 0; i < 40; i++) begin
            m = 1'($urandom_range(0, 1));
            d = $urandom >> $urandom_range(0, 31);
            stim_q.push_back(mk_model(m ? ~d : d, m, 4'(i)));
        end
        run(2, 2000, used);
        chk("rand_drained", 64'(stim_q.size() + exp_q.size()), 64'd0);

        // Reset with two transactions in flight
        stim_q.push_back(mk_model(32'h0000_00F0, 1'b0, 4'hA));
        stim_q.push_back(mk_model(32'h00F0_0000, 1'b0, 4'hB));
        run(0, 2, used);
        chk("pre_rst_full", 64'(exp_q.size()), 64'd2);
        reset_n = 1'b0;
        io.v_i = 1'b1; io.data_i = 32'h1; io.tag_i = 4'hC;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        io.v_i = 1'b0;
        exp_q.delete();
        stim_q.delete();
        chk("mid_rst_v_o",   64'(io.v_o),     64'd0);
        chk("mid_rst_ready", 64'(io.ready_o), 64'd1);
        chk("mid_rst_count", 64'(io.count_o), 64'd0);
        chk("mid_rst_all",   64'(io.all_o),   64'd0);
        chk("mid_rst_norm",  64'(io.norm_o),  64'd0);
        chk("mid_rst_tag",   64'(io.tag_o),   64'd0);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | io.v_o;
        end
        chk("no_stale_out", 64'(seen), 64'd0);
        @(posedge clk);
        #1;

        // Width/chunk sweep
        for (int i = 0; i < 12; i++) begin
            if (i == 0) begin
                sw_data = '0; sw_mode = 1'b0;
            end else if (i == 1) begin
                sw_data = '1; sw_mode = 1'b1;
            end else begin
                sw_mode = 1'($urandom_range(0, 1));
                sw_data = {$urandom, $urandom} >> $urandom_range(0, 63);
                if (sw_mode) sw_data = ~sw_data;
            end
            sw_v = 1'b1;
            @(posedge clk);
            #1 sw_v = 1'b0;
            @(posedge clk);
            @(negedge clk);
            chk_sw("w8c1",  8,  io_a.v_o, 64'(io_a.count_o), io_a.all_o, 64'(io_a.norm_o));
            chk_sw("w8c8",  8,  io_b.v_o, 64'(io_b.count_o), io_b.all_o, 64'(io_b.norm_o));
            chk_sw("w24c8", 24, io_c.v_o, 64'(io_c.count_o), io_c.all_o, 64'(io_c.norm_o));
            chk_sw("w64c1", 64, io_d.v_o, 64'(io_d.count_o), io_d.all_o, 64'(io_d.norm_o));
            @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1);
    end
endmodule
